// File: rtl/mem_access_pkg.sv
// Shared types and constants for the memory access sequencer and its byte extractor.
package mem_access_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic [1:0] LB_WORD     = 2'b00;
    localparam logic [1:0] LB_SIGNED   = 2'b01;
    localparam logic [1:0] LB_UNSIGNED = 2'b10;

    localparam int TIMEOUT_DEFAULT = 15;

    // Mode 2'b11 has no byte meaning and behaves as a full word.
    function automatic logic is_word_mode(input logic [1:0] mode);
        return (mode != LB_SIGNED) && (mode != LB_UNSIGNED);
    endfunction

endpackage

// File: rtl/mem_access_byteext.sv
// Combinational big-endian byte selection with sign or zero extension.
module byteext
    import mem_access_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  offset_i,
    input  logic [1:0]  mode_i,
    output logic [31:0] result_o
);

    logic [3:0][7:0] lanes;
    logic [7:0]      sel_byte;

    // Offset 0 addresses the most significant byte.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign lanes[gi] = word_i[31-8*gi -: 8];
        end
    endgenerate

    assign sel_byte = lanes[offset_i];

    always_comb begin
        result_o = word_i;
        case (mode_i)
            LB_SIGNED:   result_o = {{24{sel_byte[7]}}, sel_byte};
            LB_UNSIGNED: result_o = {24'h000000, sel_byte};
            default:     result_o = word_i;
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// Single-access memory sequencer: captures a request, drives the memory handshake
// with a bounded wait, and returns a registered, byte-extracted load result.
module mem_access
    import mem_access_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [1:0]  lb,
    input  logic        irwrite,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] rdata,
    output logic [31:0] instr,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
);

    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        err_q, err_d;
    logic        we_q, irwrite_q;
    logic [1:0]  lb_q, off_q;
    logic [31:0] addr_q, wdata_q;
    logic [31:0] rdata_q, rdata_d;
    logic [31:0] instr_q, instr_d;
    logic        accept, acked, misaligned;
    logic [31:0] ext_word;

    // Stores are always word-wide, so their lb field never makes them legal when unaligned.
    assign misaligned = (addr[1:0] != 2'b00) && (we || is_word_mode(lb));

    byteext u_byteext (
        .word_i   (mem_rdata),
        .offset_i (off_q),
        .mode_i   (lb_q),
        .result_o (ext_word)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = 1'b0;
        accept  = 1'b0;
        acked   = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = 8'd0;
                if (req) begin
                    accept = 1'b1;
                    if (misaligned) begin
                        state_d = DONE;
                        err_d   = 1'b1;
                    end else begin
                        state_d = ACCESS;
                    end
                end
            end
            ACCESS: begin
                if (mem_ack) begin
                    state_d = DONE;
                    acked   = 1'b1;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    state_d = DONE;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        rdata_d = rdata_q;
        instr_d = instr_q;
        if (acked && !we_q) begin
            rdata_d = ext_word;
            if (irwrite_q) begin
                instr_d = mem_rdata;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= 8'd0;
            err_q     <= 1'b0;
            we_q      <= 1'b0;
            irwrite_q <= 1'b0;
            lb_q      <= LB_WORD;
            off_q     <= 2'b00;
            addr_q    <= 32'h0;
            wdata_q   <= 32'h0;
            rdata_q   <= 32'h0;
            instr_q   <= 32'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
            instr_q <= instr_d;
            if (accept) begin
                we_q      <= we;
                irwrite_q <= irwrite;
                lb_q      <= lb;
                off_q     <= addr[1:0];
                addr_q    <= {addr[31:2], 2'b00};
                wdata_q   <= wdata;
            end
        end
    end

    // Handshake outputs decode the state register so reset removes them without waiting for a clock.
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign err       = err_q;
    assign mem_req   = (state_q == ACCESS);
    assign mem_we    = (state_q == ACCESS) && we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign rdata     = rdata_q;
    assign instr     = instr_q;

endmodule

// File: tb/tb_mem_access.sv
// Directed and randomized checks of mem_access against a transaction-level model.
module tb_mem_access;

    localparam int TIMEOUT = 15;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [1:0]  lb = 2'b00;
    logic        irwrite = 1'b0;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic        busy, done, err, mem_req, mem_we;
    logic [31:0] rdata, instr, mem_addr, mem_wdata;
    logic [31:0] mem_rdata = 32'h0;
    logic        mem_ack = 1'b0;

    int checks = 0;
    int failures = 0;
    int txn = 0;
    logic [31:0] exp_rdata = 32'h0;
    logic [31:0] exp_instr = 32'h0;

    always #5 clk = ~clk;

    mem_access #(.TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .we        (we),
        .lb        (lb),
        .irwrite   (irwrite),
        .addr      (addr),
        .wdata     (wdata),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .rdata     (rdata),
        .instr     (instr),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Expected load result: shift the addressed byte down, then widen it.
    function automatic logic [31:0] model_load(input logic [31:0] rd, input logic [1:0] off,
                                               input logic [1:0] mode);
        logic [31:0] shifted;
        logic [7:0]  b;
        shifted = rd >> (8 * (3 - int'(off)));
        b = shifted[7:0];
        if (mode == 2'b01) return 32'($signed(b));
        if (mode == 2'b10) return {24'h0, b};
        return rd;
    endfunction

    // Starts and ends at a falling edge with the DUT idle. ack_at = ACCESS cycle index of mem_ack.
    task automatic run_access(input logic w, input logic [1:0] m, input logic irw,
                              input logic [31:0] a, input logic [31:0] wd,
                              input int ack_at, input logic [31:0] rd);
        logic mis, exp_err;
        int   n_acc;
        mis = (a[1:0] != 2'b00) && (m == 2'b00 || m == 2'b11);
        exp_err = mis || (ack_at >= TIMEOUT);
        n_acc = mis ? 0 : ((ack_at < TIMEOUT) ? ack_at + 1 : TIMEOUT);
        $display("txn %0d we=%0b lb=%0d irw=%0b addr=%h wdata=%h ack_at=%0d rd=%h",
                 txn, w, m, irw, a, wd, ack_at, rd);
        txn++;
        req = 1'b1; we = w; lb = m; irwrite = irw; addr = a; wdata = wd;
        @(posedge clk); #1;
        req = 1'b0; we = ~w; lb = 2'($urandom); irwrite = ~irw;
        addr = $urandom; wdata = $urandom;
        for (int k = 0; k < n_acc; k++) begin
            @(negedge clk);
            chk("acc_mem_req", 32'(mem_req), 32'd1);
            chk("acc_mem_we", 32'(mem_we), 32'(w));
            chk("acc_mem_addr", mem_addr, {a[31:2], 2'b00});
            chk("acc_mem_wdata", mem_wdata, wd);
            chk("acc_busy", 32'(busy), 32'd1);
            chk("acc_done", 32'(done), 32'd0);
            if (k == ack_at) begin
                mem_ack = 1'b1;
                mem_rdata = rd;
            end
            @(posedge clk); #1;
            mem_ack = 1'b0;
            mem_rdata = $urandom;
        end
        if (!exp_err && !w) begin
            exp_rdata = model_load(rd, a[1:0], m);
            if (irw) exp_instr = rd;
        end
        // A request raised while done is showing must be dropped.
        req = 1'b1; we = 1'($urandom); lb = 2'b00; addr = {$urandom, 2'b00} ; wdata = $urandom;
        @(negedge clk);
        chk("done_pulse", 32'(done), 32'd1);
        chk("done_err", 32'(err), 32'(exp_err));
        chk("done_busy", 32'(busy), 32'd1);
        chk("done_mem_req", 32'(mem_req), 32'd0);
        chk("done_mem_we", 32'(mem_we), 32'd0);
        chk("done_rdata", rdata, exp_rdata);
        chk("done_instr", instr, exp_instr);
        @(posedge clk); #1;
        req = 1'b0;
        @(negedge clk);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_done", 32'(done), 32'd0);
        chk("idle_err", 32'(err), 32'd0);
        chk("idle_mem_req", 32'(mem_req), 32'd0);
    endtask

    task automatic idle_ack();
        mem_ack = 1'b1;
        mem_rdata = $urandom;
        @(posedge clk); #1;
        mem_ack = 1'b0;
        @(negedge clk);
        chk("stray_ack_rdata", rdata, exp_rdata);
        chk("stray_ack_instr", instr, exp_instr);
        chk("stray_ack_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        logic [31:0] ra;
        logic [1:0]  rm;
        logic        rw;

        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        reset = 1'b0;
        @(negedge clk);

        run_access(1'b0, 2'b00, 1'b1, 32'h10, 32'h0, 0, 32'h8C0A0004);
        run_access(1'b0, 2'b01, 1'b0, 32'h13, 32'h0, 0, 32'h123456F0);
        run_access(1'b0, 2'b10, 1'b0, 32'h13, 32'h0, 1, 32'h123456F0);
        run_access(1'b1, 2'b00, 1'b0, 32'h20, 32'hDEADBEEF, 3, 32'h55555555);
        run_access(1'b0, 2'b00, 1'b0, 32'h22, 32'h0, 0, 32'h11111111);
        run_access(1'b0, 2'b00, 1'b1, 32'h40, 32'h0, 1000, 32'h22222222);
        run_access(1'b0, 2'b11, 1'b1, 32'h44, 32'h0, TIMEOUT - 1, 32'hCAFEF00D);
        idle_ack();

        // Reset during the second ACCESS cycle.
        req = 1'b1; we = 1'b0; lb = 2'b00; irwrite = 1'b1; addr = 32'h80; wdata = 32'h0;
        @(posedge clk); #1;
        req = 1'b0;
        @(negedge clk);
        chk("pre_rst_mem_req", 32'(mem_req), 32'd1);
        @(posedge clk); #2;
        reset = 1'b1;
        #1;
        chk("midrst_mem_req", 32'(mem_req), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_rdata", rdata, 32'h0);
        chk("midrst_instr", instr, 32'h0);
        exp_rdata = 32'h0;
        exp_instr = 32'h0;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("postrst_done", 32'(done), 32'd0);
            chk("postrst_busy", 32'(busy), 32'd0);
        end
        run_access(1'b0, 2'b01, 1'b1, 32'h81, 32'h0, 2, 32'h00800000);

        for (int i = 0; i < 40; i++) begin
            ra = $urandom;
            rm = 2'($urandom);
            rw = 1'($urandom);
            if (rw && ra[1:0] != 2'b00) rm = rm[0] ? 2'b11 : 2'b00;
            run_access(rw, rm, 1'($urandom), ra, $urandom, int'($urandom_range(0, 20)), $urandom);
            if ((i % 8) == 3) idle_ack();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
